// File: rtl/fifo_queue_pkg.sv
// Shared defaults and derived widths for the fifo_queue slice.
// Pointer and count widths never fall below one bit.
package fifo_queue_pkg;

   localparam int unsigned DefWidth = 4;
   localparam int unsigned DefDepth = 5;

   function automatic int unsigned bits_for(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned PtrW = bits_for(DefDepth);
   localparam int unsigned CntW = bits_for(DefDepth + 1);

   typedef logic [PtrW-1:0] ptr_t;

endpackage

// File: rtl/fifo_queue_if.sv
// Handshake/data bundle between a queue user (master) and the fifo_queue (slave).
interface fifo_queue_if #(
   parameter int unsigned WIDTH = fifo_queue_pkg::DefWidth,
   parameter int unsigned DEPTH = fifo_queue_pkg::DefDepth
) ();

   localparam int unsigned CW = fifo_queue_pkg::bits_for(DEPTH + 1);

   logic [WIDTH-1:0] data_in;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] data_out;
   logic             full;
   logic             empty;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output data_in, push, pop,
      input  data_out, full, empty, count, overflow, underflow
   );

   modport slave (
      input  data_in, push, pop,
      output data_out, full, empty, count, overflow, underflow
   );

endinterface

// File: rtl/mod_counter.sv
// Enable-gated modulo counter: steps 0..Modulus-1 and wraps back to 0.
module mod_counter #(
   parameter int unsigned Modulus = fifo_queue_pkg::DefDepth,
   parameter int unsigned Width   = fifo_queue_pkg::bits_for(Modulus)
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             en_i,
   output logic [Width-1:0] value_o
);

   localparam logic [Width-1:0] Last = Width'(Modulus - 1);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value_o = cnt_q;

endmodule

// File: rtl/fifo_queue.sv
// Synchronous FIFO with registered read data and one-cycle overflow/underflow flags.
// Depth need not be a power of two; pointers wrap through mod_counter instances.
module fifo_queue
   import fifo_queue_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned DEPTH = DefDepth
) (
   input logic        clk,
   input logic        rstN,
   fifo_queue_if.slave bus
);

   localparam int unsigned PW = bits_for(DEPTH);
   localparam int unsigned CW = bits_for(DEPTH + 1);
   localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] data_out_q;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, underflow_q;
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             full, empty;
   logic             pop_ok, push_ok;

   // Flags come from registered count only, never from push/pop.
   assign full  = (count_q == FullCnt);
   assign empty = (count_q == '0);

   assign pop_ok  = bus.pop && !empty;
   assign push_ok = bus.push && (!full || pop_ok);

   mod_counter #(
      .Modulus (DEPTH),
      .Width   (PW)
   ) u_wr_ptr (
      .clk     (clk),
      .rstN    (rstN),
      .en_i    (push_ok),
      .value_o (wr_ptr)
   );

   mod_counter #(
      .Modulus (DEPTH),
      .Width   (PW)
   ) u_rd_ptr (
      .clk     (clk),
      .rstN    (rstN),
      .en_i    (pop_ok),
      .value_o (rd_ptr)
   );

   always_comb begin
      count_d = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage is left uncleared; unread entries are never visible on data_out.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         data_out_q  <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (pop_ok) begin
            data_out_q <= mem_q[rd_ptr];
         end
         count_q     <= count_d;
         overflow_q  <= bus.push && full && !pop_ok;
         underflow_q <= bus.pop && empty;
      end
   end

   assign bus.data_out  = data_out_q;
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.count     = count_q;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_fifo_queue.sv
// Scoreboard bench for fifo_queue: a queue-based reference model feeds expected
// per-cycle outputs to a monitor that compares them after each rising edge.
module tb_fifo_queue;

   localparam int unsigned D = 5;

   typedef struct {
      logic [3:0] dout;
      logic [2:0] cnt;
      logic       full;
      logic       empty;
      logic       ovf;
      logic       unf;
   } exp_t;

   logic clk;
   logic rstN;

   fifo_queue_if bus ();

   fifo_queue dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
   );

   int checks_total;
   int checks_passed;

   logic [3:0] model_q[$];
   logic [3:0] model_dout;
   exp_t       exp_q[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] req);
      checks_total++;
      if (act === req) begin
         checks_passed++;
      end else begin
         $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
      end
   endfunction

   // One clock of stimulus; the model decides what the queue should do from its rules.
   task automatic step(input logic ps, input logic pp, input logic [3:0] d);
      exp_t e;
      logic pop_ok;
      logic push_ok;
      @(negedge clk);
      bus.push    = ps;
      bus.pop     = pp;
      bus.data_in = d;
      pop_ok  = pp && (model_q.size() > 0);
      push_ok = ps && ((model_q.size() < D) || pop_ok);
      e.ovf   = ps && (model_q.size() == D) && !pop_ok;
      e.unf   = pp && (model_q.size() == 0);
      if (pop_ok) model_dout = model_q.pop_front();
      if (push_ok) model_q.push_back(d);
      e.dout  = model_dout;
      e.cnt   = 3'(model_q.size());
      e.full  = (model_q.size() == D);
      e.empty = (model_q.size() == 0);
      exp_q.push_back(e);
   endtask

   task automatic expect_dout(input logic [3:0] lit, input string name);
      @(posedge clk);
      #3;
      chk(name, 32'(bus.data_out), 32'(lit));
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      #1;
      rstN = 1'b0;
      model_q.delete();
      model_dout = '0;
      #1;
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_dout", 32'(bus.data_out), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_ovf", 32'(bus.overflow), 0);
      chk("rst_unf", 32'(bus.underflow), 0);
      #2;
      rstN = 1'b1;
   endtask

   // Monitor: compares the DUT against the oldest pending expectation after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("data_out", 32'(bus.data_out), 32'(e.dout));
            chk("count", 32'(bus.count), 32'(e.cnt));
            chk("full", 32'(bus.full), 32'(e.full));
            chk("empty", 32'(bus.empty), 32'(e.empty));
            chk("overflow", 32'(bus.overflow), 32'(e.ovf));
            chk("underflow", 32'(bus.underflow), 32'(e.unf));
         end
      end
   end

   initial begin
      logic [3:0] vals[5];
      logic [3:0] wrap_out[5];
      int pct_push;
      int pct_pop;
      checks_total  = 0;
      checks_passed = 0;
      model_dout    = '0;
      bus.push      = 1'b0;
      bus.pop       = 1'b0;
      bus.data_in   = '0;
      rstN          = 1'b0;
      #1;
      chk("init_count", 32'(bus.count), 0);
      chk("init_empty", 32'(bus.empty), 1);
      chk("init_full", 32'(bus.full), 0);
      chk("init_dout", 32'(bus.data_out), 0);
      #11;
      rstN = 1'b1;

      vals = '{4'd3, 4'd7, 4'd9, 4'd1, 4'd5};
      // Fill to full, then a rejected push, then drain in order.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, vals[i]);
      step(1'b1, 1'b0, 4'd12);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 4'd0);
         expect_dout(vals[i], "drain_order");
      end
      step(1'b0, 1'b0, 4'd0);

      // Wrap-around past the last index.
      wrap_out = '{4'd9, 4'd1, 4'd5, 4'd10, 4'd11};
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, vals[i]);
      step(1'b0, 1'b1, 4'd0);
      step(1'b0, 1'b1, 4'd0);
      step(1'b1, 1'b0, 4'd10);
      step(1'b1, 1'b0, 4'd11);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 4'd0);
         expect_dout(wrap_out[i], "wrap_order");
      end

      // Simultaneous push/pop on empty, then pop alone.
      step(1'b1, 1'b1, 4'd4);
      step(1'b0, 1'b1, 4'd0);
      expect_dout(4'd4, "empty_pushpop");
      chk("empty_after", 32'(bus.empty), 1);

      // Simultaneous push/pop on full; 14 comes out last.
      for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 4'(i));
      step(1'b1, 1'b1, 4'd14);
      expect_dout(4'd1, "full_pushpop");
      chk("full_pushpop_cnt", 32'(bus.count), 5);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'd0);
      expect_dout(4'd14, "full_pushpop_last");

      // Mid-operation reset discards queued words.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'(i + 6));
      step(1'b0, 1'b0, 4'd0);
      reset_pulse();
      step(1'b0, 1'b1, 4'd0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'($urandom_range(15)));

      // Random traffic with shifting push/pop bias to visit full and empty often.
      for (int blk = 0; blk < 8; blk++) begin
         pct_push = (blk % 2 == 0) ? 75 : 30;
         pct_pop  = (blk % 2 == 0) ? 30 : 75;
         if (blk == 6) begin
            pct_push = 60;
            pct_pop  = 60;
         end
         for (int i = 0; i < 40; i++) begin
            step(32'($urandom_range(99)) < pct_push, 32'($urandom_range(99)) < pct_pop,
                 4'($urandom_range(15)));
         end
      end
      step(1'b0, 1'b0, 4'd0);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      #5;
      chk("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/fifo_queue.md
FIFO_QUEUE -- requirements
Module: fifo_queue

Interface
REQ-001 Parameter WIDTH, 4, data word width in bits.
REQ-002 Parameter DEPTH, 5, number of storage entries (need not be a power of two).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstN  input  1  reset; asynchronous, active-low.
REQ-005 data_in  input  WIDTH  word to enqueue.
REQ-006 push  input  1  enqueue request, sampled on rising clk.
REQ-007 pop  input  1  dequeue request, sampled on rising clk.
REQ-008 data_out  output  WIDTH  registered oldest word from the last valid pop.
REQ-009 full  output  1  high when count == DEPTH.
REQ-010 empty  output  1  high when count == 0.
REQ-011 count  output  ceil(log2(DEPTH+1))  current occupancy.
REQ-012 overflow  output  1  one-cycle pulse: push rejected because full and no same-cycle valid pop.
REQ-013 underflow  output  1  one-cycle pulse: pop rejected because empty.

Function
REQ-014 Storage SHALL be DEPTH x WIDTH registers with write pointer wr_ptr and read pointer rd_ptr, each ranging 0..DEPTH-1.
REQ-015 Valid pop SHALL be pop && !empty; on it, data_out <= mem[rd_ptr] and rd_ptr advances; latency is 1 clk.
REQ-016 Valid push SHALL be push && (!full || valid pop); on it, mem[wr_ptr] <= data_in and wr_ptr advances.
REQ-017 Pointers SHALL wrap from DEPTH-1 to 0 with no skipped or repeated index.
REQ-018 Count SHALL be +1 for push only, -1 for pop only, and unchanged for both or neither.
REQ-019 Simultaneous push and pop when empty: pop is invalid (underflow pulses), push is accepted, and data_out holds.
REQ-020 Simultaneous push and pop when full: both are accepted, count stays DEPTH, and overflow does not pulse.
REQ-021 Push when full without pop SHALL leave memory, pointers and count unchanged, and pulse overflow.
REQ-022 Pop when empty SHALL leave data_out, pointers and count unchanged, and pulse underflow.
REQ-023 Changes on data_in while push is low SHALL have no effect.
REQ-024 full, empty and count SHALL be derived from registered state only (no combinational path from push or pop).
REQ-025 overflow and underflow SHALL be registered, asserted for exactly the cycle after the offending edge.

Reset
REQ-026 rstN low SHALL immediately clear wr_ptr, rd_ptr, count, data_out, overflow and underflow to 0, giving empty=1 and full=0.
REQ-027 Memory contents need not be cleared; they SHALL be unobservable until rewritten.
REQ-028 Reset asserted mid-operation SHALL discard all queued words; the first pop after release SHALL underflow.
REQ-029 Release of rstN SHALL take effect on the next rising clk with no spurious push or pop.

Structure
REQ-030 A shared package SHALL hold the WIDTH and DEPTH defaults, the pointer-width and count-width constants, and a ptr_t typedef.
REQ-031 The pointer wrap logic SHALL be a sub-module mod_counter (enable input, mod-DEPTH output), instantiated twice for wr_ptr and rd_ptr.
REQ-032 The RTL SHALL be synthesizable, with no latches and one always block per register group.

Verification
REQ-033 Reset, then push 3,7,9,1,5 on consecutive clks -> full=1, count=5, and no overflow pulse.
REQ-034 From full, push 12 with pop low -> overflow pulses for 1 cycle, count stays 5, and subsequent pops return 3,7,9,1,5 in order.
REQ-035 Cover wrap-around: push 5 values, pop 2, push 10,11, then pop 5 -> outputs 9,1,5,10,11, with pointers wrapping past index 4.
REQ-036 Empty, then push=pop=1 with data_in=4 -> underflow pulses and count=1; next pop alone -> data_out=4 and empty=1.
REQ-037 Full, then push=pop=1 with data_in=14 -> count stays 5, data_out becomes the oldest word, and 14 emerges last after 5 further pops.
REQ-038 With 3 words queued, pulse rstN low for half a clk -> count=0 and data_out=0 immediately; the next pop underflows; toggling data_in with push low changes nothing.
